abft_row_checker: RTL and testbench
===================================

Name: abft_row_checker

Overview:
Checksum-verification stage directly downstream of the 1x4-row by 4x4-matrix multiplier in the ABFT datapath.
- Each accepted beat is one result row z00..z03 plus its checksum product zc, computed upstream as x times the Y checksum column, where y_i4 = sum of y_ij.
- Recomputes the row sum mod 2^DW, compares it with zc, and collects pass/fail over a block of ROWS rows.
- Emits one per-block verdict through a valid/ready handshake.

Parameters:
DW, 16, width of z/zc operands; all arithmetic is mod 2^DW.
ROWS, 4, rows per block; must be ≥2.
CNT_W, 8, width of the saturating failed-block counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  row beat valid.
in_ready  out  1  checker can accept a row.
z00,z01,z02,z03  in  DW each  product row from the multiplier.
zc  in  DW  checksum-column product for the same row.
row_err  out  1  one-cycle pulse when a row's compare fails.
out_valid  out  1  block verdict valid.
out_ready  in  1  consumer accepts the verdict.
blk_err  out  1  at least one row of the block failed.
err_rows  out  ROWS  bit r set means row r failed.
err_cnt  out  CNT_W  total failed blocks since reset; saturates at all-ones.

Behaviour:
Reset values: in_ready=0, row_err=0, out_valid=0, blk_err=0, err_rows=0, err_cnt=0, row index=0, state=COLLECT. in_ready rises the cycle after rst is deasserted.

States:
- COLLECT
  - in_ready=1.
  - Handshake is in_valid & in_ready.
  - On handshake, stage-1 registers capture s=(z00+z01+z02+z03) mod 2^DW, zc and the row index.
  - The row index increments, wrapping to 0 after ROWS-1.
  - Handshake on row ROWS-1 -> DRAIN.
- Stage 2 (the cycle after capture)
  - row_err=(s!=zc) as a one-cycle pulse.
  - err_rows[idx] is ORed with the mismatch.
  - Row latency is 1 cycle; back-to-back rows are accepted every cycle.
- DRAIN
  - in_ready=0; lasts exactly 1 cycle while the last compare completes.
  - -> REPORT.
- REPORT
  - out_valid=1; blk_err=|err_rows.
  - err_rows and blk_err stay stable until out_valid & out_ready.
  - On that handshake: err_cnt += blk_err (saturating), err_rows cleared, -> COLLECT.
  - out_ready held high gives a 1-cycle REPORT.

Boundary and rule details:
- in_valid ignored while in_ready=0; the upstream holds z/zc stable.
- Block spacing with continuous valid and ready: ROWS+2 cycles per block.
- err_cnt at max with blk_err=1: holds at max.
- Reset mid-block: partial block discarded, err_rows and index cleared, no verdict emitted.
- Sum overflow wraps; a true product mismatch that aliases mod 2^DW is undetectable by design.

Optional Feature:
Macro ABFT_SYNDROME_EN.
- Defined:
  - Extra output syndrome [DW-1:0] = (zc - s) mod 2^DW of the first failing row in the block.
  - Extra output syn_row [$clog2(ROWS)-1:0] = that row's index.
  - Both are valid with out_valid and are 0 when blk_err=0.
  - Both are cleared at the verdict handshake and at reset.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Decomposition:
Shared package abft_pkg:
- state enum {COLLECT, DRAIN, REPORT}.
- default DW/ROWS/CNT_W localparams.
- helper function row_sum4(a,b,c,d) returning the mod-2^DW sum.

One natural sub-module, abft_sum_cmp: a registered 4-input adder plus comparator (stage 1/2). The top level owns the FSM, index, err_rows and counter.

Test Plan:
- Clean block: four rows with z=[1,2,3,4], zc=10, continuous valid, out_ready=1 -> out_valid 1 cycle after DRAIN; blk_err=0, err_rows=0000, err_cnt=0, no row_err.
- Single fault: block of the clean rows, but row 2 carries z02=4 (z=[1,2,4,4]), zc=10 -> row_err pulse exactly 1 cycle after row 2's handshake; err_rows=0100, blk_err=1, err_cnt=1; with ABFT_SYNDROME_EN, syndrome=0xFFFF, syn_row=2.
- Wrap: z=[0xFFFF,0x0001,0,0], zc=0x0000 -> no error; zc=0x10000 truncated to 0 also passes.
- Backpressure: out_ready=0 for 5 cycles in REPORT -> out_valid held; in_ready=0 throughout; err_rows stable; the next block starts only after the handshake.
- Saturation: CNT_W=2, five faulty blocks -> err_cnt goes 1,2,3,3,3.
- Reset mid-block: rst pulsed after 2 rows, one of them faulty -> no out_valid; err_rows=0; the next clean block reports blk_err=0 and err_cnt=0.

Source files
------------

// File: rtl/abft_pkg.sv
// Shared types and helpers for the ABFT row-checksum checker.
// Optional syndrome reporting is enabled by defining ABFT_SYNDROME_EN.
package abft_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam int DEF_DW    = 16;
    localparam int DEF_ROWS  = 4;
    localparam int DEF_CNT_W = 8;

    // Callers truncate to their own width; the low bits are the mod-2^DW sum.
    function automatic logic [63:0] row_sum4(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c, input logic [63:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/abft_sum_cmp.sv
// Stage 1 registers the row sum, checksum and index; stage 2 compares them.
module abft_sum_cmp
    import abft_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [DW-1:0]    z00,
    input  logic [DW-1:0]    z01,
    input  logic [DW-1:0]    z02,
    input  logic [DW-1:0]    z03,
    input  logic [DW-1:0]    zc,
    input  logic [IDX_W-1:0] idx,
    output logic             mismatch,
    output logic [IDX_W-1:0] cmp_idx,
    output logic [DW-1:0]    diff
);

    logic [DW-1:0] s_q;
    logic [DW-1:0] zc_q;
    logic          vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            s_q     <= '0;
            zc_q    <= '0;
            cmp_idx <= '0;
        end else begin
            vld_q <= capture;
            if (capture) begin
                s_q     <= DW'(row_sum4(64'(z00), 64'(z01), 64'(z02), 64'(z03)));
                zc_q    <= zc;
                cmp_idx <= idx;
            end
        end
    end

    assign mismatch = vld_q && (s_q != zc_q);
    assign diff     = zc_q - s_q;

endmodule

// File: rtl/abft_row_checker.sv
// Per-block ABFT row checksum verifier with a valid/ready verdict port.
// Define ABFT_SYNDROME_EN to add the syndrome/syn_row outputs.
module abft_row_checker
    import abft_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ROWS  = DEF_ROWS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    z00,
    input  logic [DW-1:0]    z01,
    input  logic [DW-1:0]    z02,
    input  logic [DW-1:0]    z03,
    input  logic [DW-1:0]    zc,
    output logic             row_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             blk_err,
    output logic [ROWS-1:0]  err_rows,
    output logic [CNT_W-1:0] err_cnt
`ifdef ABFT_SYNDROME_EN
    ,
    output logic [DW-1:0]            syndrome,
    output logic [$clog2(ROWS)-1:0]  syn_row
`endif
);

    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    state_t           state;
    state_t           next_state;
    logic             active;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             report_done;
    logic             mismatch;
    logic [IDX_W-1:0] cmp_idx;
    logic [DW-1:0]    diff;

    assign accept      = in_valid & in_ready;
    assign report_done = out_valid & out_ready;

    abft_sum_cmp #(.DW(DW), .IDX_W(IDX_W)) u_sum_cmp (
        .clk     (clk),
        .rst     (rst),
        .capture (accept),
        .z00     (z00),
        .z01     (z01),
        .z02     (z02),
        .z03     (z03),
        .zc      (zc),
        .idx     (idx),
        .mismatch(mismatch),
        .cmp_idx (cmp_idx),
        .diff    (diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = active;
                if (accept && idx == LAST_IDX) next_state = DRAIN;
            end
            DRAIN:   next_state = REPORT;
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) next_state = COLLECT;
            end
            default: next_state = COLLECT;
        endcase
    end

    // active keeps in_ready low for the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            idx      <= '0;
            err_rows <= '0;
            err_cnt  <= '0;
        end else begin
            active <= 1'b1;
            if (accept) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (report_done) begin
                err_rows <= '0;
                if (blk_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end else if (mismatch) begin
                err_rows[cmp_idx] <= 1'b1;
            end
        end
    end

    assign row_err = mismatch;
    assign blk_err = out_valid & (|err_rows);

`ifdef ABFT_SYNDROME_EN
    // Only the first failing row of a block is kept: err_rows is still empty then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syndrome <= '0;
            syn_row  <= '0;
        end else if (report_done) begin
            syndrome <= '0;
            syn_row  <= '0;
        end else if (mismatch && err_rows == '0) begin
            syndrome <= diff;
            syn_row  <= cmp_idx;
        end
    end
`endif

endmodule

// File: tb/tb_abft_row_checker.sv
// Directed self-checking bench for abft_row_checker (CNT_W=2 to reach saturation).
// Syndrome checks are compiled in when ABFT_SYNDROME_EN is defined.
module tb_abft_row_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z00, z01, z02, z03, zc;
    logic        row_err;
    logic        out_valid;
    logic        out_ready;
    logic        blk_err;
    logic [3:0]  err_rows;
    logic [1:0]  err_cnt;
`ifdef ABFT_SYNDROME_EN
    logic [15:0] syndrome;
    logic [1:0]  syn_row;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    abft_row_checker #(.DW(16), .ROWS(4), .CNT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .z00      (z00),
        .z01      (z01),
        .z02      (z02),
        .z03      (z03),
        .zc       (zc),
        .row_err  (row_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .blk_err  (blk_err),
        .err_rows (err_rows),
        .err_cnt  (err_cnt)
`ifdef ABFT_SYNDROME_EN
        ,
        .syndrome (syndrome),
        .syn_row  (syn_row)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives n rows back to back, recording in_ready before and row_err after each handshake.
    task automatic drive_rows(input int n, input logic [3:0][3:0][15:0] zs,
                              input logic [3:0][15:0] zcs,
                              output logic [3:0] rdy, output logic [3:0] rerr);
        rdy  = '0;
        rerr = '0;
        for (int r = 0; r < n; r++) begin
            in_valid = 1'b1;
            z00 = zs[r][0]; z01 = zs[r][1]; z02 = zs[r][2]; z03 = zs[r][3];
            zc  = zcs[r];
            rdy[r] = in_ready;
            step();
            rerr[r] = row_err;
        end
        in_valid = 1'b0;
    endtask

    task automatic clean_rows(output logic [3:0][3:0][15:0] zs, output logic [3:0][15:0] zcs);
        for (int r = 0; r < 4; r++) begin
            zs[r][0] = 16'd1; zs[r][1] = 16'd2; zs[r][2] = 16'd3; zs[r][3] = 16'd4;
            zcs[r]   = 16'd10;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        z00 = '0; z01 = '0; z02 = '0; z03 = '0; zc = '0;
        step(); step();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        n_cmp++; if (row_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_row_err got %b want 0", row_err); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (blk_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_blk_err got %b want 0", blk_err); end
        n_cmp++; if (err_rows !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_err_rows got %b want 0000", err_rows); end
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_err_cnt got %0d want 0", err_cnt); end
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL release_in_ready got %b want 0", in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL first_cycle_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_clean();
        logic [3:0][3:0][15:0] zs;
        logic [3:0][15:0]      zcs;
        logic [3:0]            rdy, rerr;
        clean_rows(zs, zcs);
        drive_rows(4, zs, zcs, rdy, rerr);
        n_cmp++; if (rdy !== 4'b1111) begin n_fail++; $display("[TB] FAIL clean_ready got %b want 1111", rdy); end
        n_cmp++; if (rerr !== 4'b0000) begin n_fail++; $display("[TB] FAIL clean_row_err got %b want 0000", rerr); end
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL clean_drain got rdy=%b vld=%b want 0 0", in_ready, out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL clean_out_valid got %b want 1", out_valid); end
        n_cmp++; if (blk_err !== 1'b0 || err_rows !== 4'b0000) begin n_fail++; $display("[TB] FAIL clean_verdict got blk=%b rows=%b want 0 0000", blk_err, err_rows); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL clean_after got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL clean_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_single_fault();
        logic [3:0][3:0][15:0] zs;
        logic [3:0][15:0]      zcs;
        logic [3:0]            rdy, rerr;
        clean_rows(zs, zcs);
        zs[2][2] = 16'd4;
        drive_rows(4, zs, zcs, rdy, rerr);
        n_cmp++; if (rerr !== 4'b0100) begin n_fail++; $display("[TB] FAIL fault_row_err got %b want 0100", rerr); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || blk_err !== 1'b1) begin n_fail++; $display("[TB] FAIL fault_verdict got vld=%b blk=%b want 1 1", out_valid, blk_err); end
        n_cmp++; if (err_rows !== 4'b0100) begin n_fail++; $display("[TB] FAIL fault_err_rows got %b want 0100", err_rows); end
`ifdef ABFT_SYNDROME_EN
        n_cmp++; if (syndrome !== 16'hFFFF || syn_row !== 2'd2) begin n_fail++; $display("[TB] FAIL fault_syndrome got %h/%0d want ffff/2", syndrome, syn_row); end
`endif
        step();
        n_cmp++; if (err_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL fault_err_cnt got %0d want 1", err_cnt); end
        n_cmp++; if (err_rows !== 4'b0000) begin n_fail++; $display("[TB] FAIL fault_rows_cleared got %b want 0000", err_rows); end
`ifdef ABFT_SYNDROME_EN
        n_cmp++; if (syndrome !== 16'h0 || syn_row !== 2'd0) begin n_fail++; $display("[TB] FAIL fault_syn_cleared got %h/%0d want 0/0", syndrome, syn_row); end
`endif
    endtask

    task automatic test_wrap();
        logic [3:0][3:0][15:0] zs;
        logic [3:0][15:0]      zcs;
        logic [3:0]            rdy, rerr;
        logic [16:0]           big;
        big = 17'h10000;
        for (int r = 0; r < 4; r++) begin
            zs[r][0] = 16'hFFFF; zs[r][1] = 16'h0001; zs[r][2] = 16'h0; zs[r][3] = 16'h0;
            zcs[r] = (r < 2) ? 16'h0000 : big[15:0];
        end
        drive_rows(4, zs, zcs, rdy, rerr);
        n_cmp++; if (rerr !== 4'b0000) begin n_fail++; $display("[TB] FAIL wrap_row_err got %b want 0000", rerr); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || blk_err !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_verdict got vld=%b blk=%b want 1 0", out_valid, blk_err); end
        step();
        n_cmp++; if (err_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL wrap_err_cnt got %0d want 1", err_cnt); end
    endtask

    task automatic test_backpressure();
        logic [3:0][3:0][15:0] zs;
        logic [3:0][15:0]      zcs;
        logic [3:0]            rdy, rerr;
        clean_rows(zs, zcs);
        zs[1][0] = 16'd5; zs[1][1] = 16'd5; zs[1][2] = 16'd5; zs[1][3] = 16'd5;
        zcs[1] = 16'h0010;
        out_ready = 1'b0;
        drive_rows(4, zs, zcs, rdy, rerr);
        n_cmp++; if (rerr !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp_row_err got %b want 0010", rerr); end
        step();
        // Offer a faulty row while stalled; it must be ignored.
        in_valid = 1'b1; z00 = 16'd9; z01 = 16'd9; z02 = 16'd9; z03 = 16'd9; zc = 16'd0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_rows !== 4'b0010 || row_err !== 1'b0)
                begin n_fail++; $display("[TB] FAIL bp_hold[%0d] got vld=%b rdy=%b rows=%b rerr=%b want 1 0 0010 0", i, out_valid, in_ready, err_rows, row_err); end
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (blk_err !== 1'b1 || err_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL bp_verdict got blk=%b cnt=%0d want 1 1", blk_err, err_cnt); end
`ifdef ABFT_SYNDROME_EN
        n_cmp++; if (syndrome !== 16'hFFFC || syn_row !== 2'd1) begin n_fail++; $display("[TB] FAIL bp_syndrome got %h/%0d want fffc/1", syndrome, syn_row); end
`endif
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_rows !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_release got vld=%b rdy=%b rows=%b want 0 1 0000", out_valid, in_ready, err_rows); end
        n_cmp++; if (err_cnt !== 2'd2 || row_err !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_err_cnt got cnt=%0d rerr=%b want 2 0", err_cnt, row_err); end
    endtask

    task automatic test_reset_mid_block();
        logic [3:0][3:0][15:0] zs;
        logic [3:0][15:0]      zcs;
        logic [3:0]            rdy, rerr;
        clean_rows(zs, zcs);
        zs[0][0] = 16'd1; zs[0][1] = 16'd1; zs[0][2] = 16'd1; zs[0][3] = 16'd1;
        zcs[0] = 16'd0;
        drive_rows(2, zs, zcs, rdy, rerr);
        n_cmp++; if (rerr[1:0] !== 2'b01) begin n_fail++; $display("[TB] FAIL mid_row_err got %b want 01", rerr[1:0]); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || err_rows !== 4'b0000 || in_ready !== 1'b0 || err_cnt !== 2'd0)
            begin n_fail++; $display("[TB] FAIL mid_reset got vld=%b rows=%b rdy=%b cnt=%0d want 0 0000 0 0", out_valid, err_rows, in_ready, err_cnt); end
        step();
        rst = 1'b0;
        step();
        clean_rows(zs, zcs);
        drive_rows(4, zs, zcs, rdy, rerr);
        n_cmp++; if (rdy !== 4'b1111 || rerr !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_next_block got rdy=%b rerr=%b want 1111 0000", rdy, rerr); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || blk_err !== 1'b0 || err_rows !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_verdict got vld=%b blk=%b rows=%b want 1 0 0000", out_valid, blk_err, err_rows); end
        step();
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_back_to_back_saturation();
        logic [3:0][3:0][15:0] zs;
        logic [3:0][15:0]      zcs;
        logic [3:0]            rdy, rerr;
        logic [1:0]            exp_cnt;
        clean_rows(zs, zcs);
        zs[3][0] = 16'd1; zs[3][1] = 16'd1; zs[3][2] = 16'd1; zs[3][3] = 16'd1;
        zcs[3] = 16'd5;
        for (int b = 0; b < 5; b++) begin
            exp_cnt = (b < 3) ? 2'(b + 1) : 2'd3;
            drive_rows(4, zs, zcs, rdy, rerr);
            n_cmp++; if (rdy !== 4'b1111 || rerr !== 4'b1000) begin n_fail++; $display("[TB] FAIL sat_rows[%0d] got rdy=%b rerr=%b want 1111 1000", b, rdy, rerr); end
            step();
            n_cmp++; if (out_valid !== 1'b1 || blk_err !== 1'b1 || err_rows !== 4'b1000) begin n_fail++; $display("[TB] FAIL sat_verdict[%0d] got vld=%b blk=%b rows=%b want 1 1 1000", b, out_valid, blk_err, err_rows); end
`ifdef ABFT_SYNDROME_EN
            n_cmp++; if (syndrome !== 16'h0001 || syn_row !== 2'd3) begin n_fail++; $display("[TB] FAIL sat_syndrome[%0d] got %h/%0d want 0001/3", b, syndrome, syn_row); end
`endif
            step();
            n_cmp++; if (err_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL sat_err_cnt[%0d] got %0d want %0d", b, err_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_fault();
        test_wrap();
        test_backpressure();
        test_reset_mid_block();
        test_back_to_back_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
